pq_rd_cmd_seq: RTL

- Client-side command sequencer that sits directly upstream of a replace/dequeue priority queue and drives its client port.
- Buffers DEQ/REPLACE commands from a valid/ready source in a small FIFO.
- Issues each command to the PQ as a one-cycle pulse, honouring PQ busy/empty.
- Returns the removed top entry (or an error) on a valid/ready response port.

---
 rtl/pq_rd_cmd_seq_if.sv | 44 ++++
 rtl/pq_rd_cmd_seq.sv | 108 ++++++++++
 2 files changed

// File: rtl/pq_rd_cmd_seq_if.sv
// Client-side bundle between the command sequencer and its neighbours:
// command source, response sink and the priority-queue client port.
interface pq_rd_cmd_seq_if #(
  parameter int KEY_W = 8,
  parameter int VAL_W = 8
);
  localparam int KV_W = KEY_W + VAL_W;

  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_op;
  logic [KV_W-1:0] cmd_kv;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [KV_W-1:0] rsp_kv;
  logic            rsp_err;

  logic            pq_replace;
  logic            pq_deq;
  logic [KV_W-1:0] pq_kvi;
  logic            pq_full;
  logic            pq_busy;
  logic            pq_empty;
  logic [KV_W-1:0] pq_kvo;

  modport master (
    output cmd_valid, cmd_op, cmd_kv,
    output rsp_ready,
    output pq_full, pq_busy, pq_empty, pq_kvo,
    input  cmd_ready,
    input  rsp_valid, rsp_kv, rsp_err,
    input  pq_replace, pq_deq, pq_kvi
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_kv,
    input  rsp_ready,
    input  pq_full, pq_busy, pq_empty, pq_kvo,
    output cmd_ready,
    output rsp_valid, rsp_kv, rsp_err,
    output pq_replace, pq_deq, pq_kvi
  );
endinterface

// File: rtl/pq_rd_cmd_seq.sv
// Buffers DEQ/REPLACE commands and issues them one at a time to a
// priority queue, returning the removed top entry on a response port.
module pq_rd_cmd_seq #(
  parameter int KEY_W      = 8,
  parameter int VAL_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  pq_rd_cmd_seq_if.slave   bus,
  output logic [CNT_W-1:0] ops_issued
);
  localparam int KV_W = KEY_W + VAL_W;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] LAG   = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]    state;
  logic [KV_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [KV_W:0] head;
  logic          push;
  logic          pop;
  logic          rsp_free;
  logic          head_op;

  wire unused_full = bus.pq_full;

  assign head     = mem[rd_ptr];
  assign head_op  = head[KV_W];
  assign rsp_free = !bus.rsp_valid || bus.rsp_ready;
  assign push     = bus.cmd_valid && bus.cmd_ready;
  assign pop      = (state == IDLE) && (count != '0)
                 && !bus.pq_busy && rsp_free;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_kv};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.cmd_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_kv     <= '0;
      bus.rsp_err    <= 1'b0;
      bus.pq_replace <= 1'b0;
      bus.pq_deq     <= 1'b0;
      bus.pq_kvi     <= '0;
      ops_issued     <= '0;
    end else begin
      count         <= count_nxt;
      bus.cmd_ready <= (count_nxt != FULL);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.rsp_ready) bus.rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (pop && bus.pq_empty) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_kv    <= '0;
          end else if (pop) begin
            bus.pq_deq     <= !head_op;
            bus.pq_replace <= head_op;
            bus.pq_kvi     <= head_op ? head[KV_W-1:0] : '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          bus.pq_deq     <= 1'b0;
          bus.pq_replace <= 1'b0;
          bus.rsp_valid  <= 1'b1;
          bus.rsp_kv     <= bus.pq_kvo;
          bus.rsp_err    <= 1'b0;
          ops_issued     <= ops_issued + 1'b1;
          state          <= LAG;
        end
        // busy may not be visible yet on the first cycle after issue
        LAG: state <= WAIT;
        default: begin
          if (!bus.pq_busy) state <= IDLE;
        end
      endcase
    end
  end
endmodule
